// File: rtl/control_pkg.sv
// Shared control-unit definitions: superscalar width, the queued entry format
// and the dispatch FSM state encoding.
package control_pkg;

  localparam int LOG_SUPERSCALAR_WIDTH = 2;
  localparam int SUPERSCALAR_WIDTH     = 1 << LOG_SUPERSCALAR_WIDTH;
  localparam int IQ_INSTR_WIDTH        = 32;

  // One queued instruction; copy_count is already normalised to 0..SUPERSCALAR_WIDTH.
  typedef struct packed {
    logic [IQ_INSTR_WIDTH-1:0]      instr;
    logic [LOG_SUPERSCALAR_WIDTH:0] copy_count;
    logic                           is_last;
  } iq_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISSUE = 2'd1,
    SKIP  = 2'd2
  } iq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of instruction-queue entries. Pointers carry an extra wrap
// bit so full/empty and occupancy fall straight out of the pointer values.
// Exposes both the head and the entry behind it so the issuer can pick its
// next state in the same cycle it pops.
module instr_fifo
  import control_pkg::*;
#(
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  iq_entry_t        wdata,
  output iq_entry_t        head,
  output iq_entry_t        head_next,
  output logic             full,
  output logic             empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   PTR_ONE = 1;
  localparam logic [LOG_DEPTH-1:0] IDX_ONE = 1;

  iq_entry_t            r_mem [DEPTH];
  logic [LOG_DEPTH:0]   r_wr_ptr;
  logic [LOG_DEPTH:0]   r_rd_ptr;
  logic [LOG_DEPTH-1:0] w_rd_next_idx;

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= wdata;
  end

  // Read/write pointers; binary increment toggles the wrap bit at DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign w_rd_next_idx = r_rd_ptr[LOG_DEPTH-1:0] + IDX_ONE;
  assign head      = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];
  assign head_next = r_mem[w_rd_next_idx];
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]) &&
                     (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]);
  assign count     = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/instr_queue_dispatch.sv
// Consumer end of the instruction queue: buffers decoded entries and issues
// each entry's unrolled copies one per cycle, tagged with a copy index.
// Handshake: a copy transfers on a cycle where out_valid && out_ready; while
// out_valid is high and out_ready low, out_instr/out_copy_idx/out_last_copy are
// held and out_valid does not drop. Push transfers on in_valid && in_ready,
// where in_ready is purely the inverse of the registered-pointer full flag.
module instr_queue_dispatch #(
  parameter int INSTR_WIDTH           = control_pkg::IQ_INSTR_WIDTH,
  parameter int LOG_QUEUE_DEPTH       = 3,
  parameter int LOG_SUPERSCALAR_WIDTH = control_pkg::LOG_SUPERSCALAR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INSTR_WIDTH-1:0]           in_instr,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]   in_copy_count,
  input  logic                             in_is_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INSTR_WIDTH-1:0]           out_instr,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] out_copy_idx,
  output logic                             out_last_copy,
  output logic                             program_done,
  output logic [LOG_QUEUE_DEPTH:0]         queue_count,
  output logic                             count_err,
  output logic [1:0]                       dbg_state
);

  import control_pkg::iq_entry_t;
  import control_pkg::iq_state_e;
  import control_pkg::EMPTY;
  import control_pkg::ISSUE;
  import control_pkg::SKIP;

  // Highest legal copy count (SUPERSCALAR_WIDTH) as a count-width constant.
  localparam logic [LOG_SUPERSCALAR_WIDTH:0]   MAX_COUNT = {1'b1, {LOG_SUPERSCALAR_WIDTH{1'b0}}};
  localparam logic [LOG_SUPERSCALAR_WIDTH:0]   COPY_ONE  = 1;
  localparam logic [LOG_SUPERSCALAR_WIDTH-1:0] IDX_ONE   = 1;
  localparam logic [LOG_QUEUE_DEPTH:0]         CNT_ONE   = 1;

  iq_state_e                        r_state;
  iq_state_e                        w_state_next;
  logic [LOG_SUPERSCALAR_WIDTH-1:0] r_copy_idx;
  logic [LOG_SUPERSCALAR_WIDTH-1:0] w_copy_idx_next;
  logic                             r_count_err;
  logic                             r_program_done;
  logic                             w_done_set;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_full;
  logic                             w_empty;
  logic [LOG_QUEUE_DEPTH:0]         w_count;
  iq_entry_t                        w_in_entry;
  iq_entry_t                        w_head;
  iq_entry_t                        w_head_next;
  iq_entry_t                        w_after_head;
  logic                             w_more_after_pop;
  logic                             w_last_copy;
  logic                             w_over_count;

  // State to enter when `e` becomes the head (or EMPTY if nothing will be queued).
  function automatic iq_state_e state_for(input logic avail, input iq_entry_t e);
    if (!avail)                 return EMPTY;
    else if (e.copy_count == '0) return SKIP;
    else                        return ISSUE;
  endfunction

  assign w_push       = in_valid && !w_full;
  assign in_ready     = !w_full;
  assign w_over_count = (in_copy_count > MAX_COUNT);

  // Normalise the incoming entry: counts above the superscalar width are clamped.
  always_comb begin
    w_in_entry            = '0;
    w_in_entry.instr      = in_instr;
    w_in_entry.copy_count = w_over_count ? MAX_COUNT : in_copy_count;
    w_in_entry.is_last    = in_is_last;
  end

  instr_fifo #(
    .LOG_DEPTH(LOG_QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .pop      (w_pop),
    .wdata    (w_in_entry),
    .head     (w_head),
    .head_next(w_head_next),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  // After a pop the new head is the second stored entry, or the entry being
  // pushed this cycle when the popped one was the only resident.
  assign w_more_after_pop = (w_count > CNT_ONE) || w_push;
  assign w_after_head     = (w_count > CNT_ONE) ? w_head_next : w_in_entry;
  assign w_last_copy      = ({1'b0, r_copy_idx} == (w_head.copy_count - COPY_ONE));

  // Issue FSM next-state, pop, copy counter and program_done request.
  always_comb begin
    w_state_next    = r_state;
    w_copy_idx_next = r_copy_idx;
    w_pop           = 1'b0;
    w_done_set      = 1'b0;
    out_valid       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (!w_empty)    w_state_next = state_for(1'b1, w_head);
        else if (w_push) w_state_next = state_for(1'b1, w_in_entry);
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!w_last_copy) begin
            w_copy_idx_next = r_copy_idx + IDX_ONE;
          end else begin
            w_pop           = 1'b1;
            w_copy_idx_next = '0;
            w_done_set      = w_head.is_last;
            w_state_next    = state_for(w_more_after_pop, w_after_head);
          end
        end
      end
      SKIP: begin
        w_pop        = 1'b1;
        w_done_set   = w_head.is_last;
        w_state_next = state_for(w_more_after_pop, w_after_head);
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // State, copy counter, sticky count error and registered done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= EMPTY;
      r_copy_idx     <= '0;
      r_count_err    <= 1'b0;
      r_program_done <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_copy_idx     <= w_copy_idx_next;
      r_count_err    <= r_count_err | (w_push && w_over_count);
      r_program_done <= w_done_set;
    end
  end

  assign out_instr     = w_head.instr;
  assign out_copy_idx  = r_copy_idx;
  assign out_last_copy = (r_state == ISSUE) && w_last_copy;
  assign program_done  = r_program_done;
  assign queue_count   = w_count;
  assign count_err     = r_count_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_queue_dispatch.sv
// Bench for instr_queue_dispatch: per-count vector table, hand-written
// timing/backpressure/skip/reset sequences and a randomized run scored
// against a copy-stream model.
module tb_instr_queue_dispatch;

  localparam int IW  = 32;
  localparam int LQD = 3;
  localparam int LSW = 2;
  localparam int SSW = 4;
  localparam int EW  = IW + LSW + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_instr;
  logic [LSW:0]   in_copy_count;
  logic           in_is_last;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_instr;
  logic [LSW-1:0] out_copy_idx;
  logic           out_last_copy;
  logic           program_done;
  logic [LQD:0]   queue_count;
  logic           count_err;
  logic [1:0]     dbg_state;

  instr_queue_dispatch #(
    .INSTR_WIDTH(IW),
    .LOG_QUEUE_DEPTH(LQD),
    .LOG_SUPERSCALAR_WIDTH(LSW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_copy_count(in_copy_count),
    .in_is_last   (in_is_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_copy_idx (out_copy_idx),
    .out_last_copy(out_last_copy),
    .program_done (program_done),
    .queue_count  (queue_count),
    .count_err    (count_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_fail;
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] got_q[$];

  typedef struct {
    logic [LSW:0] cnt_in;
    int           exp_copies;
    logic         exp_err;
  } vec_t;
  vec_t vecs [0:7];

  logic          pat [0:4];
  int            hs;
  int            copies;
  int            exp_done;
  int            got_done;
  logic          exp_err;
  logic          prev_stall;
  logic [EW-1:0] prev_out;
  logic [EW-1:0] item;
  int            r;
  int            n;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_instr      = '0;
    in_copy_count = '0;
    in_is_last    = 1'b0;
    out_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drive_push(input logic [IW-1:0] instr, input logic [LSW:0] cnt, input logic last);
    in_valid      = 1'b1;
    in_instr      = instr;
    in_copy_count = cnt;
    in_is_last    = last;
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_queue_count", 64'(queue_count), 64'd0);
    check("rst_count_err", 64'(count_err), 64'd0);
    check("rst_program_done", 64'(program_done), 64'd0);

    // ---------------- count table ----------------
    vecs[0] = '{cnt_in: 3'd1, exp_copies: 1, exp_err: 1'b0};
    vecs[1] = '{cnt_in: 3'd2, exp_copies: 2, exp_err: 1'b0};
    vecs[2] = '{cnt_in: 3'd3, exp_copies: 3, exp_err: 1'b0};
    vecs[3] = '{cnt_in: 3'd4, exp_copies: 4, exp_err: 1'b0};
    vecs[4] = '{cnt_in: 3'd5, exp_copies: 4, exp_err: 1'b1};
    vecs[5] = '{cnt_in: 3'd6, exp_copies: 4, exp_err: 1'b1};
    vecs[6] = '{cnt_in: 3'd7, exp_copies: 4, exp_err: 1'b1};
    vecs[7] = '{cnt_in: 3'd0, exp_copies: 0, exp_err: 1'b0};
    for (int v = 0; v < 8; v++) begin
      do_reset();
      check($sformatf("vec%0d_err_after_reset", v), 64'(count_err), 64'd0);
      drive_push(32'h1000 + 32'(v), vecs[v].cnt_in, 1'b0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      copies = 0;
      for (int c = 0; c < 12; c++) begin
        if (out_valid && out_ready) begin
          check($sformatf("vec%0d_idx", v), 64'(out_copy_idx), 64'(copies));
          check($sformatf("vec%0d_last", v), 64'(out_last_copy), 64'(copies == vecs[v].exp_copies - 1));
          copies++;
        end
        tick();
      end
      check($sformatf("vec%0d_copies", v), 64'(copies), 64'(vecs[v].exp_copies));
      check($sformatf("vec%0d_count_err", v), 64'(count_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_queue_count", v), 64'(queue_count), 64'd0);
    end

    // ---------------- count=3 latency and sequence ----------------
    do_reset();
    drive_push(32'hA, 3'd3, 1'b0);
    out_ready = 1'b1;
    check("a_pre_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("a_valid", 64'(out_valid), 64'd1);
      check("a_instr", 64'(out_instr), 64'hA);
      check("a_idx", 64'(out_copy_idx), 64'(k));
      check("a_last", 64'(out_last_copy), 64'(k == 2));
      tick();
    end
    check("a_end_valid", 64'(out_valid), 64'd0);
    check("a_end_count", 64'(queue_count), 64'd0);

    // ---------------- fill to full, refused 9th push ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_push(32'h100 + 32'(i), 3'd1, 1'b0);
      check("b_ready_before_full", 64'(in_ready), 64'd1);
      tick();
    end
    check("b_full_in_ready", 64'(in_ready), 64'd0);
    check("b_full_count", 64'(queue_count), 64'd8);
    got_q.delete();
    drive_push(32'h1FF, 3'd1, 1'b0);
    out_ready = 1'b1;
    check("b_refuse_in_ready", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) got_q.push_back(out_instr);
    tick();
    in_valid = 1'b0;
    check("b_after_refuse_count", 64'(queue_count), 64'd7);
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) got_q.push_back(out_instr);
      tick();
    end
    check("b_issued_entries", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check("b_order", 64'(got_q[i]), 64'h100 + 64'(i));
    end

    // ---------------- backpressure hold ----------------
    do_reset();
    drive_push(32'hB, 3'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1;
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      check("c_valid", 64'(out_valid), 64'd1);
      check("c_instr", 64'(out_instr), 64'hB);
      check("c_idx", 64'(out_copy_idx), 64'(hs));
      if (out_valid && out_ready) hs++;
      tick();
    end
    out_ready = 1'b0;
    check("c_handshakes", 64'(hs), 64'd2);
    check("c_end_valid", 64'(out_valid), 64'd0);

    // ---------------- zero-count skip and program_done ----------------
    do_reset();
    out_ready = 1'b1;
    drive_push(32'hC, 3'd0, 1'b0);
    tick();
    drive_push(32'hD, 3'd1, 1'b1);
    check("d_skip_valid", 64'(out_valid), 64'd0);
    check("d_skip_state", 64'(dbg_state), 64'd2);
    tick();
    in_valid = 1'b0;
    check("d_valid", 64'(out_valid), 64'd1);
    check("d_instr", 64'(out_instr), 64'hD);
    check("d_last", 64'(out_last_copy), 64'd1);
    check("d_done_early", 64'(program_done), 64'd0);
    tick();
    check("d_done_pulse", 64'(program_done), 64'd1);
    tick();
    check("d_done_clear", 64'(program_done), 64'd0);
    drive_push(32'hE, 3'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("d2_skip_valid", 64'(out_valid), 64'd0);
    check("d2_done_early", 64'(program_done), 64'd0);
    tick();
    check("d2_skip_done", 64'(program_done), 64'd1);
    check("d2_queue_count", 64'(queue_count), 64'd0);
    tick();
    check("d2_done_clear", 64'(program_done), 64'd0);

    // ---------------- reset mid-issue ----------------
    do_reset();
    drive_push(32'h50, 3'd4, 1'b0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_push(32'h50 + 32'(i), 3'd1, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("e_idx0", 64'(out_copy_idx), 64'd0);
    tick();
    check("e_idx1", 64'(out_copy_idx), 64'd1);
    check("e_count_before", 64'(queue_count), 64'd4);
    reset_n = 1'b0;
    #1;
    check("e_rst_valid", 64'(out_valid), 64'd0);
    check("e_rst_count", 64'(queue_count), 64'd0);
    check("e_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_push(32'h77, 3'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("e_new_valid", 64'(out_valid), 64'd1);
    check("e_new_instr", 64'(out_instr), 64'h77);
    check("e_new_idx", 64'(out_copy_idx), 64'd0);
    tick();
    tick();

    // ---------------- randomized run vs copy-stream model ----------------
    do_reset();
    exp_q.delete();
    exp_done   = 0;
    got_done   = 0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 720; cyc++) begin
      if (cyc < 600) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_instr = $urandom;
        r = int'($urandom_range(0, 15));
        if (r < 2)       in_copy_count = 3'd0;
        else if (r < 13) in_copy_count = 3'(1 + (r % 4));
        else             in_copy_count = 3'(5 + (r % 3));
        in_is_last = ($urandom_range(0, 9) == 0);
        out_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end

      if (program_done) got_done++;

      if (prev_stall) begin
        check("f_hold_valid", 64'(out_valid), 64'd1);
        check("f_hold_data", 64'({out_instr, out_copy_idx, out_last_copy}), 64'(prev_out));
      end

      // Model: an accepted entry expands to min(count, SSW) copies in order.
      if (in_valid && in_ready) begin
        n = (int'(in_copy_count) > SSW) ? SSW : int'(in_copy_count);
        for (int k = 0; k < n; k++) begin
          item = {in_instr, k[LSW-1:0], (k == n - 1)};
          exp_q.push_back(item);
        end
        if (in_is_last) exp_done++;
        if (int'(in_copy_count) > SSW) exp_err = 1'b1;
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("f_unexpected_copy", 64'(out_instr), 64'd0 - 64'd1);
        end else begin
          item = exp_q.pop_front();
          check("f_copy", 64'({out_instr, out_copy_idx, out_last_copy}), 64'(item));
        end
      end

      prev_stall = out_valid && !out_ready;
      prev_out   = {out_instr, out_copy_idx, out_last_copy};
      tick();
    end
    check("f_drained", 64'(exp_q.size()), 64'd0);
    check("f_done_pulses", 64'(got_done), 64'(exp_done));
    check("f_count_err", 64'(count_err), 64'(exp_err));
    check("f_queue_count", 64'(queue_count), 64'd0);
    check("f_end_valid", 64'(out_valid), 64'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_queue_dispatch.md
Name: instr_queue_dispatch

Overview:
- Consumer end of the control unit's instruction queue. The control unit pushes decoded instructions, each with a copy count of 1..SUPERSCALAR_WIDTH produced by independent-loop unrolling.
- This block buffers the entries and issues each entry's copies one per cycle to the execution side, tagged with a copy index. It also raises program_done after the final copy of the program's last instruction is accepted.

Parameters:
- INSTR_WIDTH, 32, width of an opaque decoded instruction word.
- LOG_QUEUE_DEPTH, 3, log2 of FIFO entry count (default depth 8).
- LOG_SUPERSCALAR_WIDTH, 2, log2 of SUPERSCALAR_WIDTH (default 4 copies max).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  control unit offers an entry.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  INSTR_WIDTH  instruction word.
- in_copy_count  in  LOG_SUPERSCALAR_WIDTH+1  copies to issue; legal range 1..SUPERSCALAR_WIDTH.
- in_is_last  in  1  entry is the program's final instruction.
- out_valid  out  1  copy available.
- out_ready  in  1  execution side accepts the copy.
- out_instr  out  INSTR_WIDTH  instruction of the head entry.
- out_copy_idx  out  LOG_SUPERSCALAR_WIDTH  copy index 0..count-1.
- out_last_copy  out  1  this copy is the head entry's final copy.
- program_done  out  1  one-cycle pulse.
- queue_count  out  LOG_QUEUE_DEPTH+1  occupied entries.
- count_err  out  1  sticky; an entry with count above SUPERSCALAR_WIDTH was accepted.

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - FIFO pointers, copy counter, queue_count, count_err and program_done are 0.
  - out_valid=0 and in_ready=1.
  - Reset mid-issue discards all entries and the partial copy progress.
- Push: accept on in_valid && in_ready. Entry {instr, count, is_last} is written at wr_ptr.
  - Pointers carry an extra wrap bit. Full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - in_ready depends only on the registered full flag. There is no same-cycle bypass, so a full queue refuses a push even if a pop occurs that cycle.
- Latency: an entry accepted in cycle N can first appear on out_valid in cycle N+1.
- Count normalisation happens on write:
  - count > SUPERSCALAR_WIDTH is clamped to SUPERSCALAR_WIDTH and sets count_err.
  - count = 0 is stored as 0.
- Issue FSM:
  - EMPTY: out_valid=0. Go to ISSUE, or SKIP if the head count is 0, when the queue is non-empty.
  - ISSUE:
    - out_valid=1; out_instr and out_copy_idx come from the head entry and copy counter.
    - out_last_copy = (copy_idx == count-1).
    - On out_valid && out_ready: if not the last copy, copy_idx++; otherwise pop, clear copy_idx, and move to the next state using the new head (EMPTY, ISSUE or SKIP).
  - SKIP: out_valid=0 for one cycle. Pop the zero-count entry, then next state as above. An is_last flag on a skipped entry still triggers program_done.
- Outputs are held stable while out_valid && !out_ready (valid/ready hold rule). out_valid never drops without acceptance.
- program_done is registered. It pulses in cycle N+1 when the last copy of an is_last entry is accepted (or that entry is skipped) in cycle N.
- Simultaneous push and pop: queue_count is unchanged and both pointers advance.
- Pointer wrap: index DEPTH-1 wraps to 0 and toggles the wrap bit.
- queue_count = wr_ptr - rd_ptr, using the full-width pointers.

Decomposition:
- Shared package control_pkg holds:
  - SUPERSCALAR_WIDTH and LOG_SUPERSCALAR_WIDTH (shared with the control unit's loop-increment logic).
  - A packed struct iq_entry_t {instr, copy_count, is_last}.
  - The FSM state enum {EMPTY, ISSUE, SKIP}.
- One sub-module is natural: instr_fifo.
  - Parameterised synchronous FIFO of iq_entry_t with push/pop/full/empty/count.
  - Registered storage with combinational head read.
  - Instantiated once; the issue FSM and copy counter stay in instr_queue_dispatch.

Test Plan:
- Reset, then push {instr=0xA, count=3} with out_ready=1 → out_valid rises the cycle after the push; copies idx 0,1,2 on consecutive cycles; out_last_copy only on idx 2; then out_valid=0 and queue_count=0.
- Push 8 entries with out_ready=0 → in_ready=0 after the 8th and queue_count=8. A 9th push is refused even in the cycle out_ready rises. All 8 entries are issued in push order.
- Backpressure: count=2 entry with out_ready toggling 0,1,0,0,1 → out_instr and out_copy_idx hold during stalls; exactly 2 handshakes are observed.
- Push {count=0}, then {count=1, is_last=1} → one SKIP cycle with out_valid=0; one copy issued; program_done pulses exactly one cycle after that handshake.
- Push count=7 → issued as 4 copies (idx 0..3) and count_err=1 stays set until reset.
- Assert reset_n=0 mid-way through the second copy of a count-4 entry with 3 entries queued → immediately out_valid=0, queue_count=0, in_ready=1. After release, a new entry issues from idx 0.
